ins_mem_loader: RTL and testbench
=================================

Name: ins_mem_loader

Overview:
- Writer side of the instruction-memory port; the control unit's fetch path (AR → Ins_Memory → DR) is the reader.
- Accepts a framed byte stream from a host link and assembles 12-bit instruction words.
- Writes each word into Ins_Memory through its data/wren port, which is otherwise tied off.
- Holds the processor in reset while loading, then releases it and pulses start.

Parameters:
reg_width, 12, instruction word width; must be ≤16 (two bytes per word).
Im_width, 8, instruction memory address width; must be ≤8 (count fits one byte).

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high
load_req  input  1  one-cycle request to begin a load
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte
im_address  output  Im_width  Ins_Memory address
im_data  output  reg_width  Ins_Memory write data
im_wren  output  1  Ins_Memory write enable
cpu_reset  output  1  reset to processor (high = held)
start  output  1  one-cycle start pulse to control unit
busy  output  1  load in progress
done  output  1  sticky: last load completed
error  output  1  sticky: last load aborted

Behaviour:
- Reset values: rx_ready=0, im_address=0, im_data=0, im_wren=0, cpu_reset=1, start=0, busy=0, done=0, error=0, state=IDLE.
- Byte transfer occurs on a rising edge with rx_valid=1 and rx_ready=1. rx_ready is 1 only in COUNT, LO, HI and CHK (if enabled).
- Frame format:
  - Count byte N, 1..2^Im_width−1; N=0 encodes 2^Im_width words.
  - Then per word: low byte = word[7:0], high byte = word[reg_width−1:8] in its low bits.
  - Unused high-byte bits must be 0.
- Internal word index: Im_width+1 bits, cleared at load start.
- IDLE:
  - load_req=1 → COUNT; busy=1, done=0, error=0, cpu_reset=1, index=0.
  - load_req is ignored in all other states.
- COUNT: byte accepted → store N → LO.
- LO: byte accepted → latch low byte → HI.
- HI:
  - Byte accepted with nonzero unused bits → ERR.
  - Otherwise im_data is formed → WRITE.
- WRITE:
  - im_wren=1 for exactly one cycle; im_address=index[Im_width−1:0], im_data stable.
  - Next cycle index+1.
  - If the new index equals N (or 2^Im_width when N=0) → CHK if enabled, else RELEASE; otherwise → LO.
- Latency: the write strobe occurs on the cycle after the high byte is accepted. Minimum 3 cycles per word.
- RELEASE (1 cycle): cpu_reset=0 and start=1 in the same cycle. Next cycle → IDLE with start=0, busy=0, done=1.
- ERR: error=1, busy=0, cpu_reset stays 1, im_wren=0 → IDLE. error is sticky until next load_req or reset.
- Address wrap: with N=0, addresses 0..2^Im_width−1 are written and the index stops at 2^Im_width. There is no second pass.
- rx_valid with rx_ready=0: the byte is not consumed; the upstream holds it.
- Reset mid-load: immediate return to reset values. Words already written remain in memory; no further writes occur.
- im_address/im_data hold their last values outside WRITE.

Optional Feature:
Macro LOADER_CHECKSUM_EN.
- Defined:
  - A running 8-bit XOR covers the count byte and all data bytes.
  - After the last WRITE the FSM enters CHK and accepts one checksum byte.
  - If the running XOR combined with the checksum byte is 0 → RELEASE; otherwise → ERR, processor is not started.
- Undefined: no CHK state; the frame ends after the last high byte.

Test Plan:
- Reset 2 cycles, load_req, stream N=2 plus words 0x123 (0x23,0x01) and 0xABC (0xBC,0x0A) → im_wren pulses at addr 0 data 0x123, then addr 1 data 0xABC. Then one cycle with cpu_reset=0 and start=1; done=1, busy=0.
- Same frame with rx_valid gapped (random idle cycles between bytes) → identical writes; rx_ready never drops in LO/HI; no duplicate writes.
- N=1, high byte 0x1F → error=1, cpu_reset=1, start never asserted, no im_wren after the low byte.
- N=0, 256 words of value index → 256 writes, addresses 0..255 in order, then start pulse; no write beyond 255.
- reset asserted after 3 of 5 words → all outputs at reset values next cycle; a new load_req with N=1, word 0x7FF loads correctly.
- LOADER_CHECKSUM_EN: N=1, word 0x055 (0x55,0x00), checksum 0x54 → start pulse. Checksum 0x00 → error=1, no start.

Source files
------------

// File: rtl/ins_mem_loader.sv
// Instruction-memory loader: receives a framed byte stream (count byte, then
// low/high byte pairs per word), writes each assembled word into Ins_Memory,
// holds the processor in reset while loading, then releases it and pulses start.
// Optional build macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module ins_mem_loader #(
  parameter int unsigned reg_width = 12,
  parameter int unsigned Im_width  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_req,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [Im_width-1:0]  im_address,
  output logic [reg_width-1:0] im_data,
  output logic                 im_wren,
  output logic                 cpu_reset,
  output logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] COUNT   = 3'd1;
  localparam logic [2:0] LO      = 3'd2;
  localparam logic [2:0] HI      = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] CHK     = 3'd5;
  localparam logic [2:0] RELEASE = 3'd6;
  localparam logic [2:0] ERR     = 3'd7;

  localparam int unsigned HiBits = reg_width - 8;
  // Bits of the high byte that carry word data; the rest must be zero.
  localparam logic [7:0]  HiMask = 8'((1 << HiBits) - 1);

  logic [2:0]          state_q;
  logic [7:0]          count_q;
  logic [7:0]          lo_q;
  logic [Im_width:0]   index_q;
  logic [Im_width:0]   index_nxt;
  logic [Im_width:0]   target;
  logic                accept;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]          xor_q;
`endif

  // Handshake, strobes and word-count bookkeeping decoded from the current state.
  always_comb begin
    rx_ready  = (state_q == COUNT) || (state_q == LO) || (state_q == HI) || (state_q == CHK);
    accept    = rx_valid && rx_ready;
    im_wren   = (state_q == WRITE);
    start     = (state_q == RELEASE);
    index_nxt = index_q + 1'b1;
    // A count of zero means a full memory of 2^Im_width words.
    if (count_q == 8'd0) begin
      target = {1'b1, {Im_width{1'b0}}};
    end else begin
      target = (Im_width + 1)'(count_q);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR over the count byte and every data byte of the current frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_q <= 8'd0;
    end else if (state_q == IDLE && load_req) begin
      xor_q <= 8'd0;
    end else if (accept && (state_q == COUNT || state_q == LO || state_q == HI)) begin
      xor_q <= xor_q ^ rx_data;
    end
  end
`endif

  // Load sequencer and registered status/memory-port outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      lo_q       <= 8'd0;
      index_q    <= '0;
      im_address <= '0;
      im_data    <= '0;
      cpu_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_req) begin
            state_q   <= COUNT;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            cpu_reset <= 1'b1;
            index_q   <= '0;
          end
        end
        COUNT: begin
          if (accept) begin
            count_q <= rx_data;
            state_q <= LO;
          end
        end
        LO: begin
          if (accept) begin
            lo_q    <= rx_data;
            state_q <= HI;
          end
        end
        HI: begin
          if (accept) begin
            if ((rx_data & ~HiMask) != 8'd0) begin
              state_q <= ERR;
              error   <= 1'b1;
              busy    <= 1'b0;
            end else begin
              im_data    <= {rx_data[HiBits-1:0], lo_q};
              im_address <= index_q[Im_width-1:0];
              state_q    <= WRITE;
            end
          end
        end
        WRITE: begin
          index_q <= index_nxt;
          if (index_nxt == target) begin
`ifdef LOADER_CHECKSUM_EN
            state_q   <= CHK;
`else
            state_q   <= RELEASE;
            cpu_reset <= 1'b0;
`endif
          end else begin
            state_q <= LO;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) begin
            if ((xor_q ^ rx_data) == 8'd0) begin
              state_q   <= RELEASE;
              cpu_reset <= 1'b0;
            end else begin
              state_q <= ERR;
              error   <= 1'b1;
              busy    <= 1'b0;
            end
          end
        end
`endif
        RELEASE: begin
          state_q <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
        ERR: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ins_mem_loader.sv
// Directed self-checking bench for ins_mem_loader.
module tb_ins_mem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load_req = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  im_address;
  logic [11:0] im_data;
  logic        im_wren;
  logic        cpu_reset;
  logic        start;
  logic        busy;
  logic        done;
  logic        error;

  int checks = 0;
  int errors = 0;

  logic [7:0]  wr_addr_q[$];
  logic [11:0] wr_data_q[$];
  int          start_cnt = 0;
  int          start_bad = 0;
  logic [7:0]  tb_xor = 8'd0;

  always #5 clk = ~clk;

  ins_mem_loader #(
    .reg_width(12),
    .Im_width (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_req  (load_req),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .im_address(im_address),
    .im_data   (im_data),
    .im_wren   (im_wren),
    .cpu_reset (cpu_reset),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  // Write and start monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (im_wren) begin
      wr_addr_q.push_back(im_address);
      wr_data_q.push_back(im_data);
    end
    if (start) begin
      start_cnt++;
      if (cpu_reset) start_bad++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
    start_cnt = 0;
    start_bad = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},   32'(rx_ready),   32'd0);
    check({tag, "_im_address"}, 32'(im_address), 32'd0);
    check({tag, "_im_data"},    32'(im_data),    32'd0);
    check({tag, "_im_wren"},    32'(im_wren),    32'd0);
    check({tag, "_cpu_reset"},  32'(cpu_reset),  32'd1);
    check({tag, "_start"},      32'(start),      32'd0);
    check({tag, "_busy"},       32'(busy),       32'd0);
    check({tag, "_done"},       32'(done),       32'd0);
    check({tag, "_error"},      32'(error),      32'd0);
  endtask

  task automatic start_load();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    tb_xor   = 8'd0;
  endtask

  // Offer one byte and hold it until the loader takes it; returns cycles waited.
  task automatic send_byte(input logic [7:0] b, output int waited);
    int n;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("byte_accept_timeout", 32'(n < 100), 32'd1);
    @(posedge clk);
    tb_xor = tb_xor ^ b;
    waited = n;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [11:0] w, input int gap, output int hi_wait);
    int lw;
    send_byte(w[7:0], lw);
    idle(gap);
    send_byte({4'b0000, w[11:8]}, hi_wait);
  endtask

  task automatic finish_frame();
    int w;
    logic [7:0] c;
`ifdef LOADER_CHECKSUM_EN
    c = tb_xor;
    send_byte(c, w);
`else
    c = 8'd0;
    w = c;
`endif
    idle(1);
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("end_timeout", 32'(n < 2000), 32'd1);
    @(negedge clk);
  endtask

  int w;
  int hw;

  initial begin
    // Reset for 2 cycles
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;

    // Basic two-word load
    clear_log();
    start_load();
    check("load_busy", 32'(busy), 32'd1);
    check("load_rx_ready", 32'(rx_ready), 32'd1);
    check("load_cpu_reset", 32'(cpu_reset), 32'd1);
    send_byte(8'h02, w);
    send_word(12'h123, 0, hw);
    send_word(12'hABC, 0, hw);
    finish_frame();
    wait_end();
    check("t1_nwr", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("t1_addr0", 32'(wr_addr_q[0]), 32'd0);
      check("t1_data0", 32'(wr_data_q[0]), 32'h123);
      check("t1_addr1", 32'(wr_addr_q[1]), 32'd1);
      check("t1_data1", 32'(wr_data_q[1]), 32'hABC);
    end
    check("t1_starts", 32'(start_cnt), 32'd1);
    check("t1_start_cpu_reset", 32'(start_bad), 32'd0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_error", 32'(error), 32'd0);
    check("t1_cpu_run", 32'(cpu_reset), 32'd0);

    // Same frame with idle gaps between bytes
    clear_log();
    start_load();
    check("t2_done_cleared", 32'(done), 32'd0);
    send_byte(8'h02, w);
    idle($urandom_range(1, 3));
    send_word(12'h123, $urandom_range(1, 3), hw);
    check("t2_hi0_ready", 32'(hw), 32'd0);
    idle($urandom_range(1, 3));
    send_word(12'hABC, $urandom_range(1, 3), hw);
    check("t2_hi1_ready", 32'(hw), 32'd0);
    idle($urandom_range(1, 3));
    finish_frame();
    wait_end();
    check("t2_nwr", 32'(wr_addr_q.size()), 32'd2);
    if (wr_addr_q.size() == 2) begin
      check("t2_addr0", 32'(wr_addr_q[0]), 32'd0);
      check("t2_data0", 32'(wr_data_q[0]), 32'h123);
      check("t2_addr1", 32'(wr_addr_q[1]), 32'd1);
      check("t2_data1", 32'(wr_data_q[1]), 32'hABC);
    end
    check("t2_starts", 32'(start_cnt), 32'd1);
    check("t2_done", 32'(done), 32'd1);

    // Nonzero unused high-byte bits abort the load
    clear_log();
    start_load();
    send_byte(8'h01, w);
    send_byte(8'h55, w);
    send_byte(8'h1F, w);
    idle(1);
    wait_end();
    idle(3);
    check("t3_error", 32'(error), 32'd1);
    check("t3_cpu_reset", 32'(cpu_reset), 32'd1);
    check("t3_starts", 32'(start_cnt), 32'd0);
    check("t3_nwr", 32'(wr_addr_q.size()), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_done", 32'(done), 32'd0);

    // N=0 loads the full 256-word memory
    clear_log();
    start_load();
    check("t4_error_cleared", 32'(error), 32'd0);
    send_byte(8'h00, w);
    for (int i = 0; i < 256; i++) send_word(12'(i), 0, hw);
    finish_frame();
    wait_end();
    idle(3);
    check("t4_nwr", 32'(wr_addr_q.size()), 32'd256);
    if (wr_addr_q.size() == 256) begin
      for (int i = 0; i < 256; i++) begin
        check($sformatf("t4_addr%0d", i), 32'(wr_addr_q[i]), 32'(i));
        check($sformatf("t4_data%0d", i), 32'(wr_data_q[i]), 32'(i));
      end
    end
    check("t4_starts", 32'(start_cnt), 32'd1);
    check("t4_done", 32'(done), 32'd1);

    // Reset after 3 of 5 words, then a fresh one-word load
    clear_log();
    start_load();
    send_byte(8'h05, w);
    send_word(12'h001, 0, hw);
    send_word(12'h002, 0, hw);
    send_word(12'h003, 0, hw);
    @(negedge clk);
    rx_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    reset = 1'b0;
    check("t5_nwr", 32'(wr_addr_q.size()), 32'd3);
    check("t5_starts", 32'(start_cnt), 32'd0);
    clear_log();
    start_load();
    send_byte(8'h01, w);
    send_word(12'h7FF, 0, hw);
    finish_frame();
    wait_end();
    check("t5b_nwr", 32'(wr_addr_q.size()), 32'd1);
    if (wr_addr_q.size() == 1) begin
      check("t5b_addr0", 32'(wr_addr_q[0]), 32'd0);
      check("t5b_data0", 32'(wr_data_q[0]), 32'h7FF);
    end
    check("t5b_starts", 32'(start_cnt), 32'd1);
    check("t5b_done", 32'(done), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: 0x01 ^ 0x55 ^ 0x00 = 0x54
    clear_log();
    start_load();
    send_byte(8'h01, w);
    send_byte(8'h55, w);
    send_byte(8'h00, w);
    send_byte(8'h54, w);
    idle(1);
    wait_end();
    check("cs_ok_starts", 32'(start_cnt), 32'd1);
    check("cs_ok_done", 32'(done), 32'd1);
    check("cs_ok_error", 32'(error), 32'd0);
    // Bad checksum
    clear_log();
    start_load();
    send_byte(8'h01, w);
    send_byte(8'h55, w);
    send_byte(8'h00, w);
    send_byte(8'h00, w);
    idle(1);
    wait_end();
    idle(2);
    check("cs_bad_error", 32'(error), 32'd1);
    check("cs_bad_starts", 32'(start_cnt), 32'd0);
    check("cs_bad_cpu_reset", 32'(cpu_reset), 32'd1);
    check("cs_bad_nwr", 32'(wr_addr_q.size()), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
